regfile_sweep: RTL and testbench



---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_sweep_ctrl.sv | 64 ++++++
 rtl/regfile_sweep.sv | 78 +++++++
 tb/tb_regfile_sweep.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the sweep-clearable register file.
// Holds the FSM state encoding and the default geometry.
package regfile_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;
    localparam int NUM_RD_DEF = 2;

endpackage

// File: rtl/regfile_sweep_ctrl.sv
// Bulk-clear sequencer: walks a pointer over every entry after go.
// Drives busy/done/wr_drop and the sweep write port of the array.
module sweep_ctrl
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go_i,
    input  logic              enable_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              wr_drop_o,
    output logic              swp_we_o,
    output logic [ADDR_W-1:0] swp_addr_o
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (go_i) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                ptr_d = ptr_q + ADDR_W'(1);
                // last entry is written on the same edge we leave CLEAR
                if (ptr_q == '1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign busy_o     = (state_q == ST_CLEAR);
    assign done_o     = (state_q == ST_DONE);
    assign wr_drop_o  = enable_i & busy_o;
    assign swp_we_o   = busy_o;
    assign swp_addr_o = ptr_q;

endmodule

// File: rtl/regfile_sweep.sv
// Multi-read-port register file with a one-entry-per-cycle bulk clear.
// Define REGFILE_SWEEP_BYPASS_EN to forward pending writes to the read ports.
module regfile_sweep
    import regfile_pkg::*;
#(
    parameter int                DATA_W  = DATA_W_DEF,
    parameter int                ADDR_W  = ADDR_W_DEF,
    parameter int                NUM_RD  = NUM_RD_DEF,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     go,
    input  logic                     enable,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic                     busy,
    output logic                     done,
    output logic                     wr_drop
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              swp_we;
    logic [ADDR_W-1:0] swp_addr;
    logic              user_we;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;

    sweep_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .go_i       (go),
        .enable_i   (enable),
        .busy_o     (busy),
        .done_o     (done),
        .wr_drop_o  (wr_drop),
        .swp_we_o   (swp_we),
        .swp_addr_o (swp_addr)
    );

    // the sweep owns the write port while busy
    assign user_we = enable & ~busy;
    assign mem_we  = swp_we | user_we;
    assign mem_wa  = swp_we ? swp_addr : wr_addr;
    assign mem_wd  = swp_we ? CLR_VAL : wr_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = rd_addr[g*ADDR_W +: ADDR_W];
`ifdef REGFILE_SWEEP_BYPASS_EN
        assign rd_data[g*DATA_W +: DATA_W] =
            (busy && ra == swp_addr)    ? CLR_VAL :
            (user_we && ra == wr_addr)  ? wr_data :
                                          mem_q[ra];
`else
        assign rd_data[g*DATA_W +: DATA_W] = mem_q[ra];
`endif
    end

endmodule

// File: tb/tb_regfile_sweep.sv
// Self-checking bench for regfile_sweep: default geometry and a 4x8 3-port build.
// A timestamp-based model is checked every cycle, plus directed literal checks.
module tb_regfile_sweep;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstA, goA, enA;
    logic [3:0]  waA;
    logic [31:0] wdA;
    logic [7:0]  raA;
    logic [63:0] rdA;
    logic        busyA, doneA, dropA;

    logic        rstB, goB, enB;
    logic [1:0]  waB;
    logic [7:0]  wdB;
    logic [5:0]  raB;
    logic [23:0] rdB;
    logic        busyB, doneB, dropB;

    regfile_sweep #(
        .DATA_W(32), .ADDR_W(4), .NUM_RD(2), .CLR_VAL(32'hDEAD)
    ) dutA (
        .clk(clk), .rst(rstA), .go(goA), .enable(enA),
        .wr_addr(waA), .wr_data(wdA), .rd_addr(raA), .rd_data(rdA),
        .busy(busyA), .done(doneA), .wr_drop(dropA)
    );

    regfile_sweep #(
        .DATA_W(8), .ADDR_W(2), .NUM_RD(3), .CLR_VAL(8'h5A)
    ) dutB (
        .clk(clk), .rst(rstB), .go(goB), .enable(enB),
        .wr_addr(waB), .wr_data(wdB), .rd_addr(raB), .rd_data(rdB),
        .busy(busyB), .done(doneB), .wr_drop(dropB)
    );

    int nchk = 0;
    int npass = 0;
    int nfail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act === exp) npass++;
        else begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a sweep is a timestamp S (first busy cycle); everything derives from it.
    int          cyc = 0;
    int          S [2] = '{-1000, -1000};
    int          D [2] = '{16, 4};
    logic [31:0] cv [2] = '{32'hDEAD, 32'h5A};
    logic [31:0] m [2][16];

    function automatic bit mbusy(int k, int p);
        return (p >= S[k]) && (p <= S[k] + D[k] - 1);
    endfunction

    function automatic bit mdone(int k, int p);
        return p == S[k] + D[k];
    endfunction

    function automatic void step(int k, bit r, bit g, bit e, int wa,
                                 logic [31:0] wd);
        int p;
        bit b;
        bit d;
        p = cyc;
        b = mbusy(k, p);
        d = mdone(k, p);
        if (r) begin
            for (int i = 0; i < 16; i++) m[k][i] = '0;
            S[k] = -1000;
            return;
        end
        if (b) m[k][p - S[k]] = cv[k];
        else if (e) m[k][wa] = wd;
        if (g && !b && !d) S[k] = p + 1;
    endfunction

    function automatic logic [31:0] exp_rd(int k, int ra, bit e, int wa,
                                           logic [31:0] wd);
        logic [31:0] v;
        v = m[k][ra];
`ifdef REGFILE_SWEEP_BYPASS_EN
        if (mbusy(k, cyc) && ra == cyc - S[k]) v = cv[k];
        else if (e && !mbusy(k, cyc) && ra == wa) v = wd;
`endif
        return v;
    endfunction

    always @(posedge clk) begin
        step(0, rstA, goA, enA, int'(waA), wdA);
        step(1, rstB, goB, enB, int'(waB), {24'b0, wdB});
        cyc++;
    end

    always @(negedge clk) begin : cmp
        logic [31:0] e;
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                e = exp_rd(0, int'(raA[i*4 +: 4]), enA, int'(waA), wdA);
                chk("A_rd_model", {32'b0, rdA[i*32 +: 32]}, {32'b0, e});
            end
            chk("A_busy_model", {63'b0, busyA}, {63'b0, mbusy(0, cyc)});
            chk("A_done_model", {63'b0, doneA}, {63'b0, mdone(0, cyc)});
            chk("A_drop_model", {63'b0, dropA}, {63'b0, enA & mbusy(0, cyc)});
            for (int i = 0; i < 3; i++) begin
                e = exp_rd(1, int'(raB[i*2 +: 2]), enB, int'(waB), {24'b0, wdB});
                chk("B_rd_model", {56'b0, rdB[i*8 +: 8]}, {56'b0, e[7:0]});
            end
            chk("B_busy_model", {63'b0, busyB}, {63'b0, mbusy(1, cyc)});
            chk("B_done_model", {63'b0, doneB}, {63'b0, mdone(1, cyc)});
            chk("B_drop_model", {63'b0, dropB}, {63'b0, enB & mbusy(1, cyc)});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          busy_n;
    int          done_at;
    int          done_n;
    logic [31:0] rdw_exp;

    initial begin
        rstA = 1; goA = 0; enA = 0; waA = 0; wdA = 0; raA = 0;
        rstB = 1; goB = 0; enB = 0; waB = 0; wdB = 0; raB = 0;
        tick();
        rstA = 0; rstB = 0;
        chk_en = 1;

        // reset state
        raA = {4'd7, 4'd0};
        #2;
        chk("rst_rd_0_7", {32'b0, rdA}, 64'h0);
        chk("rst_busy_done", {62'b0, busyA, doneA}, 64'h0);
        raA = {4'd15, 4'd15};
        #2;
        chk("rst_rd_15", {32'b0, rdA}, 64'h0);
        tick();

        // writes then reads
        enA = 1; waA = 1; wdA = 15; tick();
        waA = 5; wdA = 20; tick();
        waA = 15; wdA = 25; tick();
        enA = 0;
        raA = {4'd5, 4'd1};
        #2;
        chk("rd_1_5", {32'b0, rdA}, {32'd20, 32'd15});
        raA = {4'd4, 4'd15};
        #2;
        chk("rd_15_4", {32'b0, rdA}, {32'd0, 32'd25});
        tick();

        // read during write to the same address
`ifdef REGFILE_SWEEP_BYPASS_EN
        rdw_exp = 32'd77;
`else
        rdw_exp = 32'd15;
`endif
        enA = 1; waA = 1; wdA = 77; raA = {4'd5, 4'd1};
        #2;
        chk("rdw_same_addr", {32'b0, rdA[31:0]}, {32'b0, rdw_exp});
        tick();
        enA = 0;
        #2;
        chk("rdw_after_edge", {32'b0, rdA[31:0]}, 64'd77);
        tick();

        // sweep with a blocked write and a go during busy
        goA = 1; tick(); goA = 0;
        busy_n = 0; done_at = 0;
        for (int k = 1; k <= 20; k++) begin
            enA = (k == 3); waA = 3; wdA = 99; goA = (k == 5);
            #2;
            if (k == 3) chk("wr_drop_in_sweep", {63'b0, dropA}, 64'd1);
            if (busyA) busy_n++;
            if (doneA) done_at = k;
            tick();
        end
        enA = 0; goA = 0;
        chk("sweep_busy_cycles", 64'(busy_n), 64'd16);
        chk("sweep_done_cycle", 64'(done_at), 64'd17);
        for (int a = 0; a < 16; a++) begin
            raA = {4'(15 - a), 4'(a)};
            #2;
            chk("after_sweep_rd", {32'b0, rdA}, {32'hDEAD, 32'hDEAD});
            tick();
        end

        // reset in the middle of a sweep
        enA = 1; waA = 2; wdA = 32'h1234; tick();
        waA = 9; wdA = 32'h55; tick();
        enA = 0;
        goA = 1; tick(); goA = 0;
        for (int k = 1; k <= 7; k++) tick();
        rstA = 1; tick(); rstA = 0;
        #2;
        chk("rst_mid_busy", {63'b0, busyA}, 64'd0);
        done_n = 0;
        for (int k = 0; k < 20; k++) begin
            #2;
            if (doneA) done_n++;
            tick();
        end
        chk("rst_mid_no_done", 64'(done_n), 64'd0);
        for (int a = 0; a < 16; a++) begin
            raA = {4'(15 - a), 4'(a)};
            #2;
            chk("rst_mid_rd", {32'b0, rdA}, 64'h0);
            tick();
        end

        // small geometry: 4 entries, 8 bits, 3 ports
        for (int a = 0; a < 4; a++) begin
            enB = 1; waB = 2'(a); wdB = 8'((a + 1) * 11);
            tick();
        end
        enB = 0;
        raB = {2'd0, 2'd2, 2'd1};
        #2;
        chk("B_rd_slices", {40'b0, rdB}, 64'h0B2116);
        raB = {2'd3, 2'd3, 2'd2};
        #2;
        chk("B_rd_shared", {40'b0, rdB}, 64'h2C2C21);
        tick();
        goB = 1; tick(); goB = 0;
        busy_n = 0; done_at = 0;
        for (int k = 1; k <= 8; k++) begin
            #2;
            if (busyB) busy_n++;
            if (doneB) done_at = k;
            tick();
        end
        chk("B_busy_cycles", 64'(busy_n), 64'd4);
        chk("B_done_cycle", 64'(done_at), 64'd5);
        raB = {2'd3, 2'd2, 2'd1};
        #2;
        chk("B_after_sweep_a", {40'b0, rdB}, 64'h5A5A5A);
        raB = {2'd0, 2'd0, 2'd0};
        #2;
        chk("B_after_sweep_b", {40'b0, rdB}, 64'h5A5A5A);
        tick();
        tick();

        chk_en = 0;
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
